t05_stage_sequencer: RTL
========================

// Module: t05_stage_sequencer
// PURPOSE
// Parametrised top-level sequencer for the compression pipeline. It steps through NUM_STAGES
// stages in order (HIST, FLV, HTREE, CBS, TRN, SPI, ...) and supports one configurable loop-back
// (e.g. HTREE->FLV). Sits between the stage modules and the system wrapper; adds a per-stage
// watchdog, a loop limit, an error cause code and start/restart handshakes.
// PARAMETERS
// NUM_STAGES  7   number of pipeline stages (>=2)
// LOOP_FROM   2   stage index whose done may loop back (>=LOOP_TO, <NUM_STAGES)
// LOOP_TO     1   stage index re-entered on loop-back
// MAX_LOOPS   256 loop-backs allowed per run; the next one is an error
// TMO_W       16  width of watchdog timeout value/counter
// SW          $clog2(NUM_STAGES+3)  width of state_o
// PORTS
// clk          in  1           clock, rising edge
// rst          in  1           reset, asynchronous, active-high
// start_i      in  1           begin a run; honoured only in IDLE
// restart_i    in  1           leave DONE/ERROR back to IDLE
// stage_done_i in  NUM_STAGES  per-stage done; only the active stage's bit is used
// stage_err_i  in  NUM_STAGES  per-stage error; any set bit counts, active stage or not
// loop_exit_i  in  1           with LOOP_FROM done: 1 = continue forward, 0 = loop back
// timeout_i    in  TMO_W       max cycles per stage visit; 0 disables the watchdog
// stage_en_o   out NUM_STAGES  one-hot enable of the active stage; 0 outside stages
// stage_go_o   out 1           one-cycle pulse on the first cycle of every stage visit
// state_o      out SW          0=IDLE, k+1=stage k active, NUM_STAGES+1=ERROR, NUM_STAGES+2=DONE
// busy_o       out 1           a stage is active
// done_o       out 1           state is DONE
// error_o      out 1           state is ERROR
// err_code_o   out 2+SW        {cause[1:0], stage index}; cause 01=stage err, 10=timeout, 11=loop overflow
// loop_cnt_o   out $clog2(MAX_LOOPS+1)  loop-backs taken in the current run
// BEHAVIOUR
// - All outputs are registered. Reset value of every output is 0; state is IDLE.
// - IDLE: start_i=1 -> stage 0 on the next edge. stage_go_o=1 and stage_en_o[0]=1 in the following cycle.
// - Stage k active: inputs are sampled every edge. Priority per edge, highest first:
//   1. any stage_err_i bit -> ERROR, cause 01, idx = lowest set bit.
//   2. watchdog: cycle counter == timeout_i and timeout_i != 0 -> ERROR, cause 10, idx = k.
//   3. stage_done_i[k]: if k==LOOP_FROM and loop_exit_i==0 -> LOOP_TO and loop_cnt+1.
//      If loop_cnt==MAX_LOOPS before the increment -> ERROR, cause 11, idx = k.
//      Otherwise k+1. If k==NUM_STAGES-1 -> DONE.
//   4. Otherwise stay in stage k.
// - Watchdog counter: cleared on entry to each stage visit, including loop-back re-entry.
//   It increments every active cycle and saturates; it never wraps.
// - Done latency: stage_done_i high at edge N -> new stage_en_o and stage_go_o visible after edge N.
// - stage_go_o goes high on every entry, including loop-back re-entry.
// - stage_done_i bits of non-active stages are ignored. Inputs are ignored in IDLE except start_i.
// - DONE and ERROR are sticky: start_i is ignored there; restart_i=1 -> IDLE on the next edge.
//   Entering IDLE clears err_code_o and loop_cnt_o. restart_i in IDLE or during a stage is ignored.
// - err_code_o is written only on entry to ERROR and holds until leaving ERROR.
// - Any rst assertion, including mid-run, forces IDLE and zeroes all outputs immediately.
// TESTING
// - Nominal run, NUM_STAGES=7: pulse start, then each done with loop_exit=1.
//   -> state_o 1..7 then 9; done_o=1; 7 stage_go pulses.
// - Loop: LOOP_FROM done with loop_exit=0 three times, then 1.
//   -> state_o returns to 2 three times; loop_cnt_o=3; run completes DONE.
// - Error priority: stage_done_i[0] and stage_err_i[4] high in the same cycle while stage 0 is active.
//   -> state_o=8, err_code_o={01,4}.
// - Watchdog: timeout_i=5, no done -> ERROR after 5 active cycles, err_code_o={10,k}.
//   With timeout_i=0 the state holds for 1000 cycles.
// - Loop overflow: MAX_LOOPS=2, loop back 3 times -> the third loop-back gives ERROR with err_code_o={11,2}.
// - Sticky/restart/reset: start in DONE -> no change; restart -> IDLE with zeroed codes.
//   rst asserted during stage 3 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/t05_stage_sequencer.sv
// t05_stage_sequencer
// Top-level sequencer for the compression pipeline. Walks the stage modules in
// order, with one optional loop-back from LOOP_FROM to LOOP_TO. Each stage
// visit is guarded by a watchdog. The number of loop-backs per run is limited.
// Failures are reported as a cause code plus a stage index. Every output is a
// flop loaded from the next-state logic.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_i      begin a run (only looked at in IDLE)
//   restart_i    return from DONE/ERROR to IDLE
//   stage_done_i per-stage done, only the active stage's bit matters
//   stage_err_i  per-stage error, any bit counts while a stage is active
//   loop_exit_i  qualifies LOOP_FROM done: 1 = go forward, 0 = loop back
//   timeout_i    max cycles per stage visit, 0 disables the watchdog
//   stage_en_o   one-hot enable of the active stage
//   stage_go_o   pulse on the first cycle of every stage visit
//   state_o      0=IDLE, k+1=stage k, NUM_STAGES+1=ERROR, NUM_STAGES+2=DONE
//   busy_o       a stage is active
//   done_o       run finished
//   error_o      run aborted
//   err_code_o   {cause, stage index}: 01 stage err, 10 timeout, 11 loop overflow
//   loop_cnt_o   loop-backs taken in the current run
module t05_stage_sequencer #(
   parameter int NUM_STAGES = 7,
   parameter int LOOP_FROM  = 2,
   parameter int LOOP_TO    = 1,
   parameter int MAX_LOOPS  = 256,
   parameter int TMO_W      = 16,
   parameter int SW         = $clog2(NUM_STAGES + 3),
   parameter int LW         = $clog2(MAX_LOOPS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  restart_i,
   input  logic [NUM_STAGES-1:0] stage_done_i,
   input  logic [NUM_STAGES-1:0] stage_err_i,
   input  logic                  loop_exit_i,
   input  logic [TMO_W-1:0]      timeout_i,
   output logic [NUM_STAGES-1:0] stage_en_o,
   output logic                  stage_go_o,
   output logic [SW-1:0]         state_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [SW+1:0]         err_code_o,
   output logic [LW-1:0]         loop_cnt_o
);

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_RUN,
      PH_ERROR,
      PH_DONE
   } phase_t;

   phase_t                phase_q, phase_d;
   logic [SW-1:0]         stage_q, stage_d;
   logic [TMO_W-1:0]      wdog_q, wdog_d;
   logic [LW-1:0]         loopCnt_q, loopCnt_d;
   logic [SW+1:0]         errCode_q, errCode_d;
   logic [NUM_STAGES-1:0] stageEn_q, stageEn_d;
   logic                  go_q, go_d;
   logic [SW-1:0]         stateOut_q, stateOut_d;

   logic                  doneHit;
   logic [SW-1:0]         errIdx;

   // The registered one-hot enable already marks the active stage, so masking
   // the done vector with it discards done bits from every other stage.
   assign doneHit = |(stage_done_i & stageEn_q);

   // Lowest set error bit. The loop runs downward so the lowest index wins.
   always_comb begin
      errIdx = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (stage_err_i[i]) begin
            errIdx = SW'(i);
         end
      end
   end

   // Next-state logic. The watchdog counts the active cycles of the current
   // visit, including the current cycle. It therefore loads 1 on every stage
   // entry and trips on the edge that ends cycle number timeout_i. It
   // saturates instead of wrapping, so a long visit can never alias back
   // below the limit.
   always_comb begin
      phase_d   = phase_q;
      stage_d   = stage_q;
      wdog_d    = wdog_q;
      loopCnt_d = loopCnt_q;
      errCode_d = errCode_q;
      go_d      = 1'b0;

      case (phase_q)
         PH_IDLE: begin
            if (start_i) begin
               phase_d = PH_RUN;
               stage_d = '0;
               wdog_d  = TMO_W'(1);
               go_d    = 1'b1;
            end
         end

         PH_RUN: begin
            if (|stage_err_i) begin
               phase_d   = PH_ERROR;
               errCode_d = {2'b01, errIdx};
            end else if ((timeout_i != '0) && (wdog_q == timeout_i)) begin
               phase_d   = PH_ERROR;
               errCode_d = {2'b10, stage_q};
            end else if (doneHit) begin
               if ((stage_q == SW'(LOOP_FROM)) && !loop_exit_i) begin
                  if (loopCnt_q == LW'(MAX_LOOPS)) begin
                     phase_d   = PH_ERROR;
                     errCode_d = {2'b11, stage_q};
                  end else begin
                     stage_d   = SW'(LOOP_TO);
                     loopCnt_d = loopCnt_q + LW'(1);
                     wdog_d    = TMO_W'(1);
                     go_d      = 1'b1;
                  end
               end else if (stage_q == SW'(NUM_STAGES - 1)) begin
                  phase_d = PH_DONE;
               end else begin
                  stage_d = stage_q + SW'(1);
                  wdog_d  = TMO_W'(1);
                  go_d    = 1'b1;
               end
            end else if (wdog_q != '1) begin
               wdog_d = wdog_q + TMO_W'(1);
            end
         end

         PH_ERROR, PH_DONE: begin
            if (restart_i) begin
               phase_d   = PH_IDLE;
               loopCnt_d = '0;
               errCode_d = '0;
            end
         end

         default: begin
            phase_d = PH_IDLE;
         end
      endcase
   end

   // The output images are derived from the next state, so the registered
   // outputs line up with the state registers on every edge.
   always_comb begin
      stageEn_d  = '0;
      stateOut_d = '0;
      case (phase_d)
         PH_RUN: begin
            stageEn_d  = NUM_STAGES'(1) << stage_d;
            stateOut_d = stage_d + SW'(1);
         end
         PH_ERROR: stateOut_d = SW'(NUM_STAGES + 1);
         PH_DONE:  stateOut_d = SW'(NUM_STAGES + 2);
         default:  stateOut_d = '0;
      endcase
   end

   // State and output registers. A reset clears everything at once, even in
   // the middle of a run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q    <= PH_IDLE;
         stage_q    <= '0;
         wdog_q     <= '0;
         loopCnt_q  <= '0;
         errCode_q  <= '0;
         stageEn_q  <= '0;
         go_q       <= 1'b0;
         stateOut_q <= '0;
      end else begin
         phase_q    <= phase_d;
         stage_q    <= stage_d;
         wdog_q     <= wdog_d;
         loopCnt_q  <= loopCnt_d;
         errCode_q  <= errCode_d;
         stageEn_q  <= stageEn_d;
         go_q       <= go_d;
         stateOut_q <= stateOut_d;
      end
   end

   // The flag outputs are registered separately so that no output is decoded
   // combinationally from state.
   logic busy_q, done_q, error_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         busy_q  <= (phase_d == PH_RUN);
         done_q  <= (phase_d == PH_DONE);
         error_q <= (phase_d == PH_ERROR);
      end
   end

   assign stage_en_o = stageEn_q;
   assign stage_go_o = go_q;
   assign state_o    = stateOut_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign err_code_o = errCode_q;
   assign loop_cnt_o = loopCnt_q;

endmodule
